// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Accepts a request in IDLE, stalls the pipeline while dividing, presents the result for one cycle.
module div_unit (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        kill_div_i,
  input  logic        request_i,
  input  logic [2:0]  func3_i,
  input  logic        int_32_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  output logic [63:0] result_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state_reg, state_next;
  logic        is_rem_reg, int32_reg, neg_q_reg, neg_r_reg;
  logic [5:0]  cnt_reg;
  logic [63:0] r_reg, q_reg, d_reg;

  logic        is_signed, neg_a, neg_b, div_zero, overflow, special, accept;
  logic [63:0] op_a, op_b, mag_a, mag_b, most_neg;
  logic [64:0] r_shift;
  logic        fits;
  logic [5:0]  last_cnt;
  logic [63:0] q_fin, r_fin, sel, res;

  // Operand preparation at the selected width, including special-case detection
  always_comb begin
    is_signed = ~func3_i[0];
    if (int_32_i) begin
      op_a = is_signed ? {{32{src1_i[31]}}, src1_i[31:0]} : {32'b0, src1_i[31:0]};
      op_b = is_signed ? {{32{src2_i[31]}}, src2_i[31:0]} : {32'b0, src2_i[31:0]};
      most_neg = 64'hFFFF_FFFF_8000_0000;
    end else begin
      op_a = src1_i;
      op_b = src2_i;
      most_neg = 64'h8000_0000_0000_0000;
    end
    neg_a    = is_signed & op_a[63];
    neg_b    = is_signed & op_b[63];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div_zero = (op_b == 64'd0);
    overflow = is_signed & (op_a == most_neg) & (&op_b);
    special  = div_zero | overflow;
    accept   = (state_reg == IDLE) & request_i & ~kill_div_i;
  end

  // One restoring step; the restored remainder is always below the divisor so it fits in 64 bits
  assign r_shift  = {r_reg, q_reg[63]};
  assign fits     = (r_shift >= {1'b0, d_reg});
  assign last_cnt = int32_reg ? 6'd31 : 6'd63;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt_reg == last_cnt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill_div_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      is_rem_reg <= 1'b0;
      int32_reg  <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      cnt_reg    <= 6'd0;
      r_reg      <= 64'd0;
      q_reg      <= 64'd0;
      d_reg      <= 64'd0;
    end else if (accept) begin
      is_rem_reg <= func3_i[1];
      int32_reg  <= int_32_i;
      cnt_reg    <= 6'd0;
      d_reg      <= mag_b;
      if (special) begin
        // Final values loaded directly; no sign fix-up in DONE
        q_reg     <= div_zero ? {64{1'b1}} : op_a;
        r_reg     <= div_zero ? op_a : 64'd0;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else begin
        q_reg     <= int_32_i ? {mag_a[31:0], 32'b0} : mag_a;
        r_reg     <= 64'd0;
        neg_q_reg <= neg_a ^ neg_b;
        neg_r_reg <= neg_a;
      end
    end else if ((state_reg == DIVIDE) && !kill_div_i) begin
      r_reg   <= fits ? (r_shift[63:0] - d_reg) : r_shift[63:0];
      q_reg   <= {q_reg[62:0], fits};
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  always_comb begin
    q_fin = neg_q_reg ? -q_reg : q_reg;
    r_fin = neg_r_reg ? -r_reg : r_reg;
    sel   = is_rem_reg ? r_fin : q_fin;
    res   = int32_reg ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

  assign result_o = ((state_reg == DONE) && !kill_div_i) ? res : 64'd0;
  assign stall_o  = ~kill_div_i & ((state_reg == DIVIDE) | ((state_reg == IDLE) & request_i));

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, special cases, kill and async reset.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        kill_div_i;
  logic        request_i;
  logic [2:0]  func3_i;
  logic        int_32_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic [63:0] result_o;
  logic        stall_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_unit dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .kill_div_i (kill_div_i),
    .request_i  (request_i),
    .func3_i    (func3_i),
    .int_32_i   (int_32_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .result_o   (result_o),
    .stall_o    (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request in cycle 0, then follow stall_o until it drops (bounded)
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] exp);
    int cyc;
    int bad;
    logic [63:0] got;
    @(negedge clk_i);
    func3_i = f3; int_32_i = w; src1_i = a; src2_i = b; request_i = 1'b1;
    #1;
    check({tag, "_stall_c0"}, {63'd0, stall_o}, 64'd1);
    cyc = 0;
    bad = 0;
    got = 64'd0;
    while (cyc < 100) begin
      @(negedge clk_i);
      request_i = 1'b0;
      src1_i = {$urandom, $urandom};
      src2_i = {$urandom, $urandom};
      func3_i = 3'($urandom);
      int_32_i = 1'($urandom);
      #1;
      cyc++;
      if (!stall_o) break;
      if (result_o != 64'd0) bad++;
    end
    got = result_o;
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_result"}, got, exp);
    check({tag, "_result_while_stalled"}, 64'(bad), 64'd0);
    @(negedge clk_i);
    #1;
    check({tag, "_result_after_done"}, result_o, 64'd0);
    $display("op %-10s f3=%b w=%0d a=%h b=%h -> result=%h cycles=%0d", tag, f3, w, a, b, got, cyc);
  endtask

  initial begin
    rstn_i = 1'b0; kill_div_i = 1'b0; request_i = 1'b0;
    func3_i = 3'd0; int_32_i = 1'b0; src1_i = 64'd0; src2_i = 64'd0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_stall", {63'd0, stall_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    run_op("div_m20_3",  F_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 65, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("rem_m20_3",  F_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("remu_20_3",  F_REMU, 1'b0, 64'd20, 64'd3, 65, 64'd2);
    run_op("divu_max_2", F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op("divu_5_0",   F_DIVU, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_7_0",    F_REM,  1'b0, 64'd7, 64'd0, 1, 64'd7);
    run_op("remw_x_0",   F_REM,  1'b1, 64'h1234_5678_8000_0001, 64'd0, 1, 64'hFFFF_FFFF_8000_0001);
    run_op("div_ovf",    F_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
    run_op("rem_ovf",    F_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    run_op("divw_ovf",   F_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000);
    run_op("divuw_big",  F_DIVU, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 64'hCAFE_0000_0000_0001, 33, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divw_100_m7", F_DIV, 1'b1, 64'd100, 64'h0000_0000_FFFF_FFF9, 33, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("remw_m7_2",  F_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);

    // Kill in cycle 10 of a DIV, then a fresh DIV in cycle 12
    @(negedge clk_i);
    func3_i = F_DIV; int_32_i = 1'b0; src1_i = 64'hFFFF_FFFF_FFFF_FFEC; src2_i = 64'd3; request_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      request_i = 1'b0;
      if (c == 10) kill_div_i = 1'b1;
    end
    #1;
    check("kill_stall", {63'd0, stall_o}, 64'd0);
    check("kill_result", result_o, 64'd0);
    @(negedge clk_i);
    kill_div_i = 1'b0;
    #1;
    check("kill_idle_stall", {63'd0, stall_o}, 64'd0);
    $display("op kill       aborted DIV in cycle 10");
    run_op("div_after_kill", F_DIV, 1'b0, 64'd100, 64'd7, 65, 64'd14);

    // Same sequence with an asynchronous reset pulse in cycle 20
    @(negedge clk_i);
    func3_i = F_DIV; int_32_i = 1'b0; src1_i = 64'hFFFF_FFFF_FFFF_FFEC; src2_i = 64'd3; request_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      request_i = 1'b0;
      if (c == 20) rstn_i = 1'b0;
    end
    #1;
    check("rst_stall", {63'd0, stall_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("rst_idle_stall", {63'd0, stall_o}, 64'd0);
    $display("op reset      aborted DIV in cycle 20");
    run_op("div_after_rst", F_DIV, 1'b0, 64'd100, 64'd7, 65, 64'd14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the scalar pipeline. It executes the RV64M divide and remainder group: DIV, DIVU, REM, REMU and their 32-bit W forms. It sits beside `mul_unit` in the execute stage and shares its request/kill/stall handshake. A divide holds the pipeline through `stall_o` and returns its result for exactly one cycle.

## Interface
Parameters: none.

Ports:
- `clk_i`  in  1  clock
- `rstn_i`  in  1  reset, asynchronous, active-low
- `kill_div_i`  in  1  flush; aborts any in-flight operation
- `request_i`  in  1  divide instruction present in execute
- `func3_i`  in  3  RISC-V funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `int_32_i`  in  1  W variant (operate on bits [31:0])
- `src1_i`  in  64  dividend
- `src2_i`  in  64  divisor
- `result_o`  out  64  result; valid only in the DONE cycle, 0 otherwise
- `stall_o`  out  1  hold pipeline while the divide is in progress

## Operation
- States:
  - IDLE: waiting for a request.
  - DIVIDE: one quotient bit per cycle.
  - DONE: result cycle.
- Acceptance:
  - Occurs in IDLE when `request_i & ~kill_div_i`.
  - Latched at acceptance: `func3_i`, `int_32_i`, operand magnitudes, quotient sign, remainder sign.
  - Inputs are don't-care after acceptance.
- W forms:
  - Operands are taken from [31:0].
  - DIVW/REMW sign-extend from bit 31; DIVUW/REMUW zero-extend.
  - The final 32-bit result is always sign-extended to 64 bits, including for the unsigned forms.
- Signed ops:
  - Divide magnitudes.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
  - Negate in two's complement in DONE.
- Algorithm (restoring, on registers R (65b) and Q (64b); N = 64, or 32 for W):
  - Q is initialised to |dividend| (left-aligned to bit N-1 for W).
  - Each DIVIDE cycle: shift {R,Q} left 1, compute D = R − |divisor|.
  - If D ≥ 0, set R = D and Q[0] = 1.
- Special cases are detected at acceptance. They go IDLE→DONE directly and skip DIVIDE:
  - Divisor zero: quotient = all ones (−1); remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (dividend = most-negative, divisor = −1, at the op width): quotient = dividend; remainder = 0.
- Result selection: DIV/DIVU → quotient; REM/REMU → remainder.
- Transitions:
  - IDLE→DIVIDE (normal request) or IDLE→DONE (special case).
  - DIVIDE→DONE after N iterations; a 6-bit counter counts them.
  - DONE→IDLE unconditionally.
  - Any state→IDLE when `kill_div_i`.
- Kill:
  - Combinationally forces `stall_o`=0 and `result_o`=0 in the same cycle.
  - Next state is IDLE.
  - No residue: the next request starts clean.
- Requests in DIVIDE or DONE are ignored. The pipeline re-presents the instruction from IDLE.

## Timing
- Reset: state IDLE; all datapath registers 0; `stall_o`=0; `result_o`=0.
- Request accepted in cycle 0: `stall_o`=1 combinationally in cycle 0.
- Normal op:
  - DIVIDE occupies cycles 1..N.
  - DONE occurs in cycle N+1: `stall_o`=0, `result_o` valid.
  - Latency: 65 cycles (64-bit) or 33 cycles (W).
- Special case: DONE in cycle 1, with `stall_o`=0 and the result valid.
- `stall_o` is high from cycle 0 through the last DIVIDE cycle, and low in DONE and IDLE (absent a request).
- `result_o` is nonzero only in the DONE cycle; it is 0 in every other cycle.
- Earliest next acceptance: the cycle after DONE.
- Reset asserted mid-operation: immediate return to IDLE; outputs 0.

## Test plan
- DIV, src1=0xFFFF_FFFF_FFFF_FFEC (−20), src2=3 → `stall_o` high cycles 0–64; cycle 65 `result_o`=0xFFFF_FFFF_FFFF_FFFA (−6), `stall_o`=0; cycle 66 `result_o`=0.
- REM −20/3 → 0xFFFF_FFFF_FFFF_FFFE; REMU 20/3 → 2; DIVU 0xFFFF_FFFF_FFFF_FFFF/2 → 0x7FFF_FFFF_FFFF_FFFF. All results valid in cycle 65.
- Divide by zero:
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF in cycle 1.
  - REM 7/0 → 7 in cycle 1.
  - REMW with src1=0x1234_5678_8000_0001, src2=0 → 0xFFFF_FFFF_8000_0001.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000 in cycle 1.
  - REM of the same operands → 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- DIVUW with src1=0xDEAD_BEEF_FFFF_FFFE, src2=0xCAFE_0000_0000_0001 → cycle 33 `result_o`=0xFFFF_FFFF_FFFF_FFFE. This confirms upper bits are ignored and the result is sign-extended.
- Kill `kill_div_i` in cycle 10 of a DIV → `stall_o`=0 and `result_o`=0 in cycle 10, IDLE in cycle 11. A new DIV 100/7 accepted in cycle 12 returns 14 in cycle 77. Repeat the sequence with `rstn_i` pulsed low in cycle 20 in place of the kill; outputs must read 0 immediately.
